// File: rtl/rr_arbiter8_pkg.sv
// Shared types, sizes and the rotate/priority-encode arbitration helper
// for the eight-client round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int unsigned N_CLIENTS = 8;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } arb_pick_t;

  // Rotate req right by ptr, take the lowest set bit, then add ptr back mod 8.
  function automatic arb_pick_t arb_pick(input logic [N_CLIENTS-1:0] req,
                                         input logic [IDX_W-1:0]     ptr);
    logic [2*N_CLIENTS-1:0] w_dbl;
    logic [N_CLIENTS-1:0]   w_rot;
    arb_pick_t              w_res;
    w_dbl = {req, req} >> ptr;
    w_rot = w_dbl[N_CLIENTS-1:0];
    w_res = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_res.valid = 1'b1;
        w_res.idx   = IDX_W'(i);
      end
    end
    w_res.idx = w_res.idx + ptr;
    return w_res;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the eight clients and the arbiter.
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic [N_CLIENTS-1:0] req;
  logic                 done;
  logic [N_CLIENTS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic                 timeout;

  modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter8_decoder.sv
// 3-to-8 one-hot decoder used to turn the registered winner index into a grant vector.
module rr_arbiter8_decoder
  import rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0]     i_idx,
  output logic [N_CLIENTS-1:0] o_dec_c
);

  always_comb begin
    o_dec_c        = '0;
    o_dec_c[i_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight clients: registered winner index, held grant
// released on done, request drop, or hold-limit expiry.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr,   w_ptr_nxt;
  logic [IDX_W-1:0] r_idx,   w_idx_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic                 w_rel_done, w_rel_drop, w_rel_lim, w_release;
  logic [IDX_W-1:0]     w_ptr_arb;
  arb_pick_t            w_pick;
  logic [N_CLIENTS-1:0] w_dec;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign w_rel_done = bus.done;
  assign w_rel_drop = ~bus.req[r_idx];
  assign w_rel_lim  = (r_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_release  = w_rel_done | w_rel_drop | w_rel_lim;

  // On release the pointer moves past the grantee before re-arbitrating.
  assign w_ptr_arb = (r_state == ST_GRANT) ? (r_idx + IDX_W'(1)) : r_ptr;
  assign w_pick    = arb_pick(bus.req, w_ptr_arb);

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick.valid) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_pick.idx;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt     = w_ptr_arb;
          w_timeout_nxt = w_rel_lim & ~w_rel_done & ~w_rel_drop;
          w_cnt_nxt     = '0;
          if (w_pick.valid) begin
            w_idx_nxt = w_pick.idx;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  rr_arbiter8_decoder u_dec (
    .i_idx   (r_idx),
    .o_dec_c (w_dec)
  );

  assign bus.gnt_valid = (r_state == ST_GRANT);
  assign bus.gnt_idx   = r_idx;
  assign bus.timeout   = r_timeout;
  assign bus.gnt       = w_dec & {N_CLIENTS{bus.gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): reset, handover order,
// pointer wrap, hold-limit release and asynchronous reset mid-grant.
module tb_rr_arbiter8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rr_arbiter8_if u_if ();

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] idx);
    logic [7:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    chk({tag, "_valid"}, 8'(u_if.gnt_valid), 8'h01);
    chk({tag, "_idx"},   8'(u_if.gnt_idx),   8'(idx));
    chk({tag, "_gnt"},   u_if.gnt,           oh);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 8'(u_if.gnt_valid), 8'h00);
    chk({tag, "_gnt"},   u_if.gnt,           8'h00);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    u_if.req  = 8'hFF;
    u_if.done = 1'b0;

    // Reset held with all clients requesting
    step();
    step();
    chk_idle("rst");
    chk("rst_to", 8'(u_if.timeout), 8'h00);
    chk("rst_idx", 8'(u_if.gnt_idx), 8'h00);
    rst_n = 1'b1;
    step();
    chk_grant("first", 3'd0);
    u_if.req = 8'h00;
    step();
    chk_idle("drop0");
    chk("hold_idx", 8'(u_if.gnt_idx), 8'h00);

    // Single client, release with done; ptr then sits at 3
    u_if.req = 8'b0000_0100;
    step();
    chk_grant("single", 3'd2);
    u_if.done = 1'b1;
    u_if.req  = 8'h00;
    step();
    chk_idle("single_rel");
    u_if.done = 1'b0;
    u_if.req  = 8'b0000_1100;
    step();
    chk_grant("ptr3", 3'd3);

    // Move pointer to 0 via client 7, then full contention
    u_if.req = 8'h80;
    step();
    chk_grant("to7", 3'd7);
    u_if.req = 8'h00;
    step();
    chk_idle("idle_p0");
    u_if.req = 8'hFF;
    step();
    chk_grant("ff0", 3'd0);
    u_if.done = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_grant("ff_order", 3'(i % 8));
    end
    u_if.done = 1'b0;

    // Pointer wrap 7 -> 0 -> 2
    u_if.req = 8'h80;
    step();
    chk_grant("wrap7", 3'd7);
    u_if.req  = 8'b1000_0101;
    u_if.done = 1'b1;
    step();
    chk_grant("wrap0", 3'd0);
    step();
    chk_grant("wrap2", 3'd2);
    u_if.done = 1'b0;
    u_if.req  = 8'h00;
    step();
    chk_idle("wrap_idle");

    // Hold-limit release: 4 granted cycles, then timeout pulse with no gap
    u_if.req = 8'b0010_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_grant("hold", 3'd5);
      chk("hold_to", 8'(u_if.timeout), 8'h00);
    end
    step();
    chk_grant("regrant5", 3'd5);
    chk("to_pulse", 8'(u_if.timeout), 8'h01);
    step();
    chk("to_clear", 8'(u_if.timeout), 8'h00);
    step();
    step();
    chk_grant("hold4th", 3'd5);
    u_if.done = 1'b1;
    step();
    chk_grant("done_lim", 3'd5);
    chk("done_lim_to", 8'(u_if.timeout), 8'h00);
    u_if.done = 1'b0;

    // Asynchronous reset while client 6 holds the grant
    u_if.req = 8'h40;
    step();
    chk_grant("g6", 3'd6);
    #2;
    rst_n    = 1'b0;
    u_if.req = 8'hFF;
    #1;
    chk_idle("async_rst");
    chk("async_idx", 8'(u_if.gnt_idx), 8'h00);
    chk("async_to", 8'(u_if.timeout), 8'h00);
    #2;
    rst_n = 1'b1;
    step();
    chk_grant("post_rst", 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter sharing one resource among eight requesters. Arbitration produces a registered 3-bit winner index. That index drives a 3-to-8 one-hot decoder to form the grant vector. Each grant is held until the grantee signals completion, drops its request, or exceeds a hold limit. The block sits between eight client request lines and the shared-resource select logic.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held before forced release; legal range 2..256.
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request per client; bit i = client i.
- `done`  in  1  current grantee releases the resource; sampled only while `gnt_valid`=1.
- `gnt`  out  8  one-hot grant; all zero when `gnt_valid`=0.
- `gnt_idx`  out  3  index of current grantee; holds its last value when idle.
- `gnt_valid`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse marking a forced release.

## Operation
- States: IDLE and GRANT. `gnt_valid`=1 exactly in GRANT.
- Reset values: state IDLE; `gnt`, `gnt_idx`, `gnt_valid` and `timeout` all 0; pointer `ptr`=0; hold counter `cnt`=0.
- Winner selection: scan `req` starting at bit `ptr` and moving upward modulo 8. The first set bit wins.
- IDLE behaviour:
  - If `req`≠0, register the winner into `gnt_idx` and go to GRANT with `cnt`=0.
  - Otherwise stay in IDLE.
- GRANT behaviour: a release occurs when any of the following holds.
  - (a) `done`=1.
  - (b) `req[gnt_idx]`=0.
  - (c) `cnt`==MAX_HOLD-1.
  - If none holds, `cnt` increments.
- On release:
  - Set `ptr` to `gnt_idx`+1, wrapping 7→0.
  - Re-arbitrate in the same cycle using the new `ptr` and the current `req`.
  - If a winner exists, stay in GRANT with the new `gnt_idx` and `cnt`=0. Otherwise go to IDLE.
  - The releasing client has lowest priority, so it is re-granted only when it is the sole requester.
- `timeout` is registered. It is 1 for exactly the one cycle after a release caused solely by (c).
  - If (a) or (b) holds in the same cycle as (c), `timeout` stays 0.
- `gnt` = `gnt_valid` ? decode(`gnt_idx`) : 0. This is combinational from registers only, so it is glitch-free relative to `clk`.
- `done` is ignored in IDLE.
- `req` bits for clients other than the grantee never pre-empt a grant.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. `req` sampled high at edge k gives `gnt` valid after edge k.
- Back-to-back handover: zero dead cycles. The new grantee's `gnt` is valid in the cycle immediately after the release edge.
- Maximum grant length: MAX_HOLD cycles.
- Worst-case wait for a continuously requesting client: 7×MAX_HOLD cycles.
- Reset mid-grant: on `rst_n` falling, all outputs clear immediately (asynchronously). Arbitration resumes with `ptr`=0 on the first edge after deassertion.
- `cnt` width is clog2(MAX_HOLD). The counter never wraps; release at MAX_HOLD-1 occurs first.

## Structure
- Shared package holds:
  - `N_CLIENTS`=8 and `IDX_W`=3.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
- Sub-module: the team's existing 3-to-8 one-hot `Decoder`, instantiated once to map `gnt_idx` to the raw one-hot vector. That vector is ANDed with `gnt_valid`.
- Arbitration lives in a combinational function:
  - Rotate `req` right by `ptr`.
  - Apply a priority encoder.
  - Add `ptr` back modulo 8.

## Test plan
- Reset: hold `rst_n`=0 with `req`=8'hFF. Required: `gnt`=0, `gnt_valid`=0, `timeout`=0. After release of reset, the first grant is `gnt_idx`=0.
- Single client: `req`=8'b0000_0100. Required: `gnt`=8'b0000_0100 one cycle later. Pulse `done`: `gnt`=0 the next cycle, and `ptr`=3.
- Full contention: `req`=8'hFF with `done` pulsed once per grant. Required: grant order 0,1,2,3,4,5,6,7,0 with no idle cycles between grants.
- Pointer wrap: grant client 7 with `req`=8'b1000_0101, then `done`. Required: next `gnt_idx`=0, then 2 after the next `done`.
- Timeout, with MAX_HOLD=4: `req`=8'b0010_0000 held, `done` never asserted. Required:
  - `gnt`=8'b0010_0000 for 4 cycles, then `timeout`=1 for one cycle.
  - Client 5 is re-granted with no gap.
  - Repeat with `done` asserted on the 4th cycle: `timeout` stays 0.
- Reset mid-grant: assert `rst_n`=0 while `gnt_idx`=6. Required: outputs clear without waiting for a clock edge, and post-reset arbitration starts from `ptr`=0.
